// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin UART transmitter with message locking
module uart_tx_scheduler #(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic       req0_last,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic [1:0] grant,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic [12:0] WRAP = 13'(DELAY_FRAMES - 1);
  logic [1:0] state;
  logic [12:0] cnt;
  logic [2:0] idx;
  logic [7:0] data;
  logic lock, ptr, win, sel_valid, accept, wrap;
  // ptr is both the last-served requester and, while locked, the owner
  always_comb begin
    win = lock ? ptr : (req0_valid && req1_valid) ? ~ptr : req1_valid;
    sel_valid = win ? req1_valid : req0_valid;
    accept = state == IDLE && !rst && sel_valid;
    req0_ready = accept && !win;
    req1_ready = accept && win;
    wrap = cnt == WRAP;
    busy = state != IDLE;
    grant = (busy || lock) ? {ptr, ~ptr} : (req0_valid || req1_valid) ? {win, ~win} : 2'b00;
    uart_tx = state == START ? 1'b0 : state == DATA ? data[idx] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      lock <= 1'b0;
      ptr <= 1'b1;
    end else if (state == IDLE) begin
      cnt <= '0;
      idx <= '0;
      if (accept) begin
        state <= START;
        data <= win ? req1_data : req0_data;
        lock <= !(win ? req1_last : req0_last);
        ptr <= win;
      end
    end else begin
      cnt <= wrap ? 13'd0 : cnt + 13'd1;
      if (wrap) begin
        idx <= state == DATA ? idx + 3'd1 : 3'd0;
        state <= state == START ? DATA : state == DATA ? (idx == 3'd7 ? STOP : DATA) : IDLE;
      end
    end
  end
endmodule
